// File: rtl/mac_addr_swap.sv
// mac_addr_swap
//   AXI4-Stream byte stage for the loopback path. Collects the first 12
//   bytes of a frame (destination MAC, then source MAC), re-emits them with
//   the two addresses exchanged, then passes the rest of the frame through.
//   Frames of 12 bytes or fewer are replayed unswapped and marked errored.
//
// Ports
//   axis_clk, axis_rstn      clock, asynchronous active-low reset
//   s_axis_*                 input stream (tdata/tvalid/tlast/tuser, tready out)
//   m_axis_*                 output stream, tdata/tvalid/tlast/tuser registered
//   frame_cnt                frames that went through the header/pass path
//   short_cnt                frames replayed as short/errored
module mac_addr_swap #(
    parameter bit SWAP_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic             axis_clk,
    input  logic             axis_rstn,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic             s_axis_tready,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] short_cnt
);

    typedef enum logic [1:0] {COLLECT, HDR, PASS, SHORT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [3:0]         n_q, n_d;
    logic [7:0]         hdr_buf_q [12];
    logic               buf_we;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               out_user_q, out_user_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   short_cnt_q, short_cnt_d;
    // Holds tready low for the first cycle out of reset so tready reads 0
    // while reset is asserted.
    logic               run_q;
    logic               can_load;
    logic               s_hs;

    // Header output index k -> buffer index.
    function automatic logic [3:0] hdr_sel(input logic [3:0] k);
        if (!SWAP_EN)
            return k;
        else if (k < 4'd6)
            return k + 4'd6;
        else
            return k - 4'd6;
    endfunction

    assign can_load = !out_valid_q || m_axis_tready;
    assign s_hs     = s_axis_tvalid && s_axis_tready;

    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_hdr_buf
            always_ff @(posedge axis_clk or negedge axis_rstn) begin
                if (!axis_rstn)
                    hdr_buf_q[gi] <= 8'h00;
                else if (buf_we && idx_q == 4'(gi))
                    hdr_buf_q[gi] <= s_axis_tdata;
            end
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        n_d           = n_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_user_d    = out_user_q;
        frame_cnt_d   = frame_cnt_q;
        short_cnt_d   = short_cnt_q;
        buf_we        = 1'b0;
        s_axis_tready = 1'b0;

        // A drained register empties unless something below reloads it.
        if (can_load)
            out_valid_d = 1'b0;

        case (state_q)
            COLLECT: begin
                s_axis_tready = run_q && can_load;
                if (s_hs) begin
                    buf_we = 1'b1;
                    if (s_axis_tlast) begin
                        n_d     = idx_q + 4'd1;
                        idx_d   = 4'd0;
                        state_d = SHORT;
                    end else if (idx_q == 4'd11) begin
                        // Header byte 0 never depends on byte 11, so it is
                        // loaded on the 12th handshake to avoid a bubble.
                        out_data_d  = hdr_buf_q[hdr_sel(4'd0)];
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        out_user_d  = 1'b0;
                        idx_d       = 4'd1;
                        state_d     = HDR;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            HDR: begin
                if (can_load) begin
                    out_data_d  = hdr_buf_q[hdr_sel(idx_q)];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    out_user_d  = 1'b0;
                    if (idx_q == 4'd11) begin
                        idx_d   = 4'd0;
                        state_d = PASS;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            PASS: begin
                s_axis_tready = can_load;
                if (s_hs) begin
                    out_data_d  = s_axis_tdata;
                    out_valid_d = 1'b1;
                    out_last_d  = s_axis_tlast;
                    out_user_d  = s_axis_tlast && s_axis_tuser;
                    if (s_axis_tlast) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        idx_d       = 4'd0;
                        state_d     = COLLECT;
                    end
                end
            end
            SHORT: begin
                if (can_load) begin
                    out_data_d  = hdr_buf_q[idx_q];
                    out_valid_d = 1'b1;
                    out_last_d  = (idx_q == n_q - 4'd1);
                    out_user_d  = (idx_q == n_q - 4'd1);
                    if (idx_q == n_q - 4'd1) begin
                        short_cnt_d = short_cnt_q + 1'b1;
                        idx_d       = 4'd0;
                        state_d     = COLLECT;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                idx_d   = 4'd0;
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            state_q     <= COLLECT;
            idx_q       <= 4'd0;
            n_q         <= 4'd0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            frame_cnt_q <= '0;
            short_cnt_q <= '0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
            frame_cnt_q <= frame_cnt_d;
            short_cnt_q <= short_cnt_d;
            run_q       <= 1'b1;
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tuser  = out_user_q;
    assign frame_cnt     = frame_cnt_q;
    assign short_cnt     = short_cnt_q;

endmodule

// File: tb/tb_mac_addr_swap.sv
module tb_mac_addr_swap;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_user = 1'b0;
    logic        m_ready = 1'b1;
    logic        bp_en = 1'b0;

    logic        s_ready1, m_valid1, m_last1, m_user1;
    logic [7:0]  m_data1;
    logic [15:0] fcnt1, scnt1;
    logic        s_ready0, m_valid0, m_last0, m_user0;
    logic [7:0]  m_data0;
    logic [2:0]  fcnt0, scnt0;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int stab_err  = 0;
    int lat_err   = 0;

    logic [9:0] out1_q[$];
    logic [9:0] out0_q[$];
    logic [9:0] exp1_q[$];
    logic [9:0] exp0_q[$];
    logic [7:0] in_q[$];
    int ob1 = 0, ob0 = 0, eb1 = 0, eb0 = 0;

    always #5 clk = ~clk;

    mac_addr_swap #(.SWAP_EN(1'b1), .CNT_W(16)) u_dut (
        .axis_clk(clk), .axis_rstn(rstn),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
        .s_axis_tuser(s_user), .s_axis_tready(s_ready1),
        .m_axis_tdata(m_data1), .m_axis_tvalid(m_valid1), .m_axis_tlast(m_last1),
        .m_axis_tuser(m_user1), .m_axis_tready(m_ready),
        .frame_cnt(fcnt1), .short_cnt(scnt1)
    );

    mac_addr_swap #(.SWAP_EN(1'b0), .CNT_W(3)) u_dut_ns (
        .axis_clk(clk), .axis_rstn(rstn),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
        .s_axis_tuser(s_user), .s_axis_tready(s_ready0),
        .m_axis_tdata(m_data0), .m_axis_tvalid(m_valid0), .m_axis_tlast(m_last0),
        .m_axis_tuser(m_user0), .m_axis_tready(m_ready),
        .frame_cnt(fcnt0), .short_cnt(scnt0)
    );

    // Downstream ready, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        logic       hold;
        logic [9:0] prev;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (hold && (!m_valid1 || {m_last1, m_user1, m_data1} !== prev))
                stab_err++;
            if (m_valid1 !== m_valid0 || s_ready1 !== s_ready0)
                lat_err++;
            if (m_valid1 && m_ready) out1_q.push_back({m_last1, m_user1, m_data1});
            if (m_valid0 && m_ready) out0_q.push_back({m_last0, m_user0, m_data0});
            hold = m_valid1 && !m_ready;
            prev = {m_last1, m_user1, m_data1};
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
        bit ok;
        ok = 1'b0;
        s_data = d; s_last = l; s_user = u; s_valid = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (s_ready1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
        check_cnt++;
        if (!ok) $display("FAIL input_handshake: tready stayed %0b, required 1", s_ready1);
        else pass_cnt++;
    endtask

    // Reference output of one frame held in in_q, for both address modes.
    task automatic push_expected(input int len, input bit usr);
        for (int i = 0; i < len; i++) begin
            logic       l;
            logic [7:0] sw;
            l = (i == len - 1);
            if (len <= 12) begin
                exp1_q.push_back({l, l, in_q[i]});
                exp0_q.push_back({l, l, in_q[i]});
            end else begin
                sw = (i < 6) ? in_q[i + 6] : (i < 12) ? in_q[i - 6] : in_q[i];
                exp1_q.push_back({l, l & usr, sw});
                exp0_q.push_back({l, l & usr, in_q[i]});
            end
        end
    endtask

    task automatic send_frame(input int len, input bit usr);
        push_expected(len, usr);
        for (int i = 0; i < len; i++)
            send_byte(in_q[i], i == len - 1, usr && (i == len - 1));
    endtask

    // Wait for all expected bytes, then count differences for each DUT.
    task automatic drain(output int mm1, output int mm0);
        int n1, n0;
        n1 = exp1_q.size() - eb1;
        n0 = exp0_q.size() - eb0;
        for (int t = 0; t < 4000; t++) begin
            if (out1_q.size() - ob1 >= n1 && out0_q.size() - ob0 >= n0) break;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
        mm1 = (out1_q.size() - ob1 != n1) ? 1 : 0;
        mm0 = (out0_q.size() - ob0 != n0) ? 1 : 0;
        for (int i = 0; i < n1; i++)
            if (ob1 + i < out1_q.size() && out1_q[ob1 + i] !== exp1_q[eb1 + i]) mm1++;
        for (int i = 0; i < n0; i++)
            if (ob0 + i < out0_q.size() && out0_q[ob0 + i] !== exp0_q[eb0 + i]) mm0++;
        ob1 = out1_q.size(); eb1 = exp1_q.size();
        ob0 = out0_q.size(); eb0 = exp0_q.size();
    endtask

    task automatic fill_std64();
        in_q.delete();
        for (int i = 0; i < 6; i++) in_q.push_back(8'hFF);
        for (int i = 0; i < 6; i++) in_q.push_back(8'(i * 8'h11));
        for (int i = 12; i < 64; i++) in_q.push_back(8'(i));
    endtask

    task automatic test_reset();
        logic [63:0] v;
        repeat (3) @(posedge clk);
        #1;
        v = {m_valid1, m_data1, m_last1, m_user1, s_ready1, fcnt1, scnt1,
             m_valid0, m_data0, m_last0, m_user0, s_ready0, fcnt0, scnt0};
        check_cnt++;
        if (v !== 64'h0) $display("FAIL reset_outputs: got %h required 0", v);
        else pass_cnt++;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cnt++;
        if (s_ready1 !== 1'b1) $display("FAIL ready_after_reset: got %0b required 1", s_ready1);
        else pass_cnt++;
    endtask

    task automatic test_swap();
        int mm1, mm0;
        fill_std64();
        send_frame(64, 1'b0);
        drain(mm1, mm0);
        check_cnt++;
        if (mm1 !== 0) $display("FAIL swap_stream: %0d byte errors, required 0", mm1);
        else pass_cnt++;
        check_cnt++;
        if (fcnt1 !== 16'd1) $display("FAIL swap_frame_cnt: got %0d required 1", fcnt1);
        else pass_cnt++;
        $display("test_swap: frame_cnt=%0d", fcnt1);
    endtask

    task automatic test_error();
        int mm1, mm0;
        fill_std64();
        send_frame(64, 1'b1);
        drain(mm1, mm0);
        check_cnt++;
        if (mm1 !== 0) $display("FAIL error_stream: %0d byte errors, required 0", mm1);
        else pass_cnt++;
        check_cnt++;
        if (out1_q[ob1 - 1] !== {2'b11, 8'h3F})
            $display("FAIL error_last_byte: got %h required 33f", out1_q[ob1 - 1]);
        else pass_cnt++;
        check_cnt++;
        if (fcnt1 !== 16'd2) $display("FAIL error_frame_cnt: got %0d required 2", fcnt1);
        else pass_cnt++;
        $display("test_error: frame_cnt=%0d", fcnt1);
    endtask

    task automatic test_backpressure();
        int mm1, mm0;
        bp_en = 1'b1;
        for (int f = 0; f < 10; f++) begin
            in_q.delete();
            for (int i = 0; i < 60; i++) in_q.push_back(8'($urandom_range(0, 255)));
            send_frame(60, 1'b0);
        end
        drain(mm1, mm0);
        bp_en = 1'b0;
        @(posedge clk);
        #1;
        check_cnt++;
        if (mm1 !== 0) $display("FAIL bp_stream: %0d byte errors, required 0", mm1);
        else pass_cnt++;
        check_cnt++;
        if (stab_err !== 0) $display("FAIL bp_stable: %0d unstable cycles, required 0", stab_err);
        else pass_cnt++;
        check_cnt++;
        if (fcnt1 !== 16'd12) $display("FAIL bp_frame_cnt: got %0d required 12", fcnt1);
        else pass_cnt++;
        check_cnt++;
        if (fcnt0 !== 3'd4) $display("FAIL bp_cnt_wrap: got %0d required 4", fcnt0);
        else pass_cnt++;
        $display("test_backpressure: frame_cnt=%0d narrow_cnt=%0d", fcnt1, fcnt0);
    endtask

    task automatic test_short();
        int mm1, mm0;
        in_q.delete();
        for (int i = 1; i <= 7; i++) in_q.push_back(8'(i));
        send_frame(7, 1'b0);
        drain(mm1, mm0);
        check_cnt++;
        if (mm1 !== 0) $display("FAIL short_stream: %0d byte errors, required 0", mm1);
        else pass_cnt++;
        check_cnt++;
        if (out1_q[ob1 - 1] !== {2'b11, 8'h07})
            $display("FAIL short_last_byte: got %h required 307", out1_q[ob1 - 1]);
        else pass_cnt++;
        check_cnt++;
        if ({scnt1, fcnt1} !== {16'd1, 16'd12})
            $display("FAIL short_counters: got short=%0d frame=%0d required 1 12", scnt1, fcnt1);
        else pass_cnt++;
        $display("test_short: short_cnt=%0d", scnt1);
    endtask

    task automatic test_boundary();
        int mm1, mm0;
        in_q.delete();
        for (int i = 0; i < 12; i++) in_q.push_back(8'h80 + 8'(i));
        send_frame(12, 1'b0);
        drain(mm1, mm0);
        check_cnt++;
        if (mm1 !== 0 || scnt1 !== 16'd2)
            $display("FAIL boundary_12: errors=%0d short=%0d required 0 2", mm1, scnt1);
        else pass_cnt++;
        in_q.delete();
        for (int i = 0; i < 13; i++) in_q.push_back(8'h40 + 8'(i));
        send_frame(13, 1'b1);
        drain(mm1, mm0);
        check_cnt++;
        if (mm1 !== 0 || out1_q[ob1 - 7] !== {2'b00, 8'h40} || out1_q[ob1 - 1] !== {2'b11, 8'h4C})
            $display("FAIL boundary_13: errors=%0d last=%h required 0 34c", mm1, out1_q[ob1 - 1]);
        else pass_cnt++;
        check_cnt++;
        if (fcnt1 !== 16'd13) $display("FAIL boundary_frame_cnt: got %0d required 13", fcnt1);
        else pass_cnt++;
        $display("test_boundary: frame_cnt=%0d short_cnt=%0d", fcnt1, scnt1);
    endtask

    task automatic test_reset_mid();
        int mm1, mm0;
        logic [63:0] v;
        fill_std64();
        for (int i = 0; i < 20; i++) send_byte(in_q[i], 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        v = {m_valid1, m_data1, m_last1, m_user1, s_ready1, fcnt1, scnt1,
             m_valid0, m_data0, m_last0, m_user0, s_ready0, fcnt0, scnt0};
        check_cnt++;
        if (v !== 64'h0) $display("FAIL midreset_outputs: got %h required 0", v);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        ob1 = out1_q.size();
        ob0 = out0_q.size();
        send_frame(64, 1'b0);
        drain(mm1, mm0);
        check_cnt++;
        if (mm1 !== 0) $display("FAIL midreset_stream: %0d byte errors, required 0", mm1);
        else pass_cnt++;
        check_cnt++;
        if ({fcnt1, scnt1} !== {16'd1, 16'd0})
            $display("FAIL midreset_counters: got frame=%0d short=%0d required 1 0", fcnt1, scnt1);
        else pass_cnt++;
        $display("test_reset_mid: frame_cnt=%0d short_cnt=%0d", fcnt1, scnt1);
    endtask

    task automatic test_swap_en0();
        int mm1, mm0;
        fill_std64();
        send_frame(64, 1'b0);
        drain(mm1, mm0);
        check_cnt++;
        if (mm0 !== 0) $display("FAIL noswap_stream: %0d byte errors, required 0", mm0);
        else pass_cnt++;
        check_cnt++;
        if (lat_err !== 0) $display("FAIL noswap_latency: %0d differing cycles, required 0", lat_err);
        else pass_cnt++;
        check_cnt++;
        if (fcnt0 !== 3'd2) $display("FAIL noswap_frame_cnt: got %0d required 2", fcnt0);
        else pass_cnt++;
        $display("test_swap_en0: frame_cnt=%0d", fcnt0);
    endtask

    initial begin
        test_reset();
        test_swap();
        test_error();
        test_backpressure();
        test_short();
        test_boundary();
        test_reset_mid();
        test_swap_en0();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
